// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory-path transaction controller.
package spi_pkg;

  localparam int WORD_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 4;

  localparam logic READ_FLAG = 1'b1;

  // Encoding is visible on the optional status port, so keep the listed order.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET       = 3'd1,
    GOT       = 3'd2,
    READ_LOAD = 3'd3,
    READ_SEND = 3'd4,
    WRITE_GET = 3'd5,
    WRITE_MEM = 3'd6,
    DONE      = 3'd7
  } spi_state_e;

endpackage

// File: rtl/spi_fsm_if.sv
// Strobe/handshake bundle between the SPI transaction controller and its neighbours.
// With SPI_FSM_STATUS_EN defined, the bundle also carries fsmState and abortCount.
interface spi_fsm_if;

  logic sclkPosEdge;
  logic csConditioned;
  logic shiftRegOutP0;
  logic srWe;
  logic addrWe;
  logic dmWe;
  logic misoBufe;

`ifdef SPI_FSM_STATUS_EN
  logic [2:0] fsmState;
  logic [7:0] abortCount;

  modport master (
    output sclkPosEdge, csConditioned, shiftRegOutP0,
    input  srWe, addrWe, dmWe, misoBufe, fsmState, abortCount
  );

  modport slave (
    input  sclkPosEdge, csConditioned, shiftRegOutP0,
    output srWe, addrWe, dmWe, misoBufe, fsmState, abortCount
  );
`else
  modport master (
    output sclkPosEdge, csConditioned, shiftRegOutP0,
    input  srWe, addrWe, dmWe, misoBufe
  );

  modport slave (
    input  sclkPosEdge, csConditioned, shiftRegOutP0,
    output srWe, addrWe, dmWe, misoBufe
  );
`endif

endinterface

// File: rtl/spi_bit_counter.sv
// SCLK bit counter shared by every counting phase of a transaction.
// terminal fires on the enable pulse that completes a WORD_WIDTH-bit frame.
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WORD_WIDTH - 1);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Wrapping back to zero on the terminal pulse keeps the count within one frame.
  always_comb begin
    terminal = enable && (count_q == LAST);
    count_d  = count_q;
    if (clear || terminal) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_fsm.sv
// SPI memory-path transaction controller: frames address and data bits and issues
// the load/latch/write/MISO-enable strobes. SPI_FSM_STATUS_EN exposes state and abort count.
module spi_fsm
  import spi_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic      clk,
  input  logic      resetN,
  spi_fsm_if.slave  bus
);

  spi_state_e state_q, state_d;

  logic abort;
  logic counting;
  logic cnt_clear;
  logic cnt_enable;
  logic cnt_terminal;

  logic sr_we_q;
  logic addr_we_q;
  logic dm_we_q;
  logic miso_bufe_q;

  spi_bit_counter #(
    .WORD_WIDTH (WORD_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .resetN   (resetN),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  // Chip-select release outranks everything, including a coincident SCLK pulse.
  always_comb begin
    abort      = (state_q != IDLE) && bus.csConditioned;
    counting   = (state_q == GET) || (state_q == READ_SEND) || (state_q == WRITE_GET);
    cnt_enable = counting && bus.sclkPosEdge && !abort;
    cnt_clear  = !counting || abort;

    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (!bus.csConditioned) state_d = GET;
        GET:       if (cnt_terminal) state_d = GOT;
        GOT:       state_d = (bus.shiftRegOutP0 == READ_FLAG) ? READ_LOAD : WRITE_GET;
        READ_LOAD: state_d = READ_SEND;
        READ_SEND: if (cnt_terminal) state_d = DONE;
        WRITE_GET: if (cnt_terminal) state_d = WRITE_MEM;
        WRITE_MEM: state_d = DONE;
        DONE:      state_d = DONE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q glitch-free.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      sr_we_q     <= 1'b0;
      addr_we_q   <= 1'b0;
      dm_we_q     <= 1'b0;
      miso_bufe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_we_q     <= (state_d == READ_LOAD);
      addr_we_q   <= (state_d == GOT);
      dm_we_q     <= (state_d == WRITE_MEM);
      miso_bufe_q <= (state_d == READ_SEND);
    end
  end

  assign bus.srWe     = sr_we_q;
  assign bus.addrWe   = addr_we_q;
  assign bus.dmWe     = dm_we_q;
  assign bus.misoBufe = miso_bufe_q;

`ifdef SPI_FSM_STATUS_EN
  logic [7:0] abort_count_q, abort_count_d;

  // Leaving DONE on chip-select release is a normal finish, not an abort.
  always_comb begin
    abort_count_d = abort_count_q;
    if (abort && (state_q != DONE) && (abort_count_q != 8'hFF)) begin
      abort_count_d = abort_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      abort_count_q <= 8'd0;
    end else begin
      abort_count_q <= abort_count_d;
    end
  end

  assign bus.fsmState   = state_q;
  assign bus.abortCount = abort_count_q;
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// Directed, table-driven bench for spi_fsm plus hand-written reset and abort sequences.
// Status-port checks are compiled in only when SPI_FSM_STATUS_EN is defined.
module tb_spi_fsm;

  typedef struct {
    logic       cs;
    logic       sclk;
    logic       p0;
    logic [3:0] exp;
  } vec_t;

  logic clk;
  logic resetN;
  int   vecCount;
  int   missCount;
  vec_t vecs[$];

  spi_fsm_if bus();

  spi_fsm #(
    .WORD_WIDTH (8),
    .CNT_WIDTH  (4)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic cs, input logic sclk, input logic p0, input logic [3:0] exp);
    vecs.push_back('{cs, sclk, p0, exp});
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic applyStimulus(input logic cs, input logic sclk, input logic p0);
    bus.csConditioned = cs;
    bus.sclkPosEdge   = sclk;
    bus.shiftRegOutP0 = p0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {bus.srWe, bus.addrWe, bus.dmWe, bus.misoBufe};
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: srWe/addrWe/dmWe/misoBufe got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    resetN    = 1'b0;
    bus.csConditioned = 1'b1;
    bus.sclkPosEdge   = 1'b0;
    bus.shiftRegOutP0 = 1'b0;

    // Write: 8 address pulses, flag 0, 8 data pulses, then 4 extra pulses in DONE.
    addVec(1'b0, 1'b0, 1'b0, 4'b0000);
    for (int i = 1; i <= 8; i++) begin
      addVec(1'b0, 1'b1, 1'b0, {1'b0, (i == 8), 2'b00});
      addVec(1'b0, 1'b0, 1'b0, 4'b0000);
    end
    for (int i = 1; i <= 8; i++) begin
      addVec(1'b0, 1'b1, 1'b0, {2'b00, (i == 8), 1'b0});
      addVec(1'b0, 1'b0, 1'b0, 4'b0000);
    end
    for (int i = 17; i <= 20; i++) begin
      addVec(1'b0, 1'b1, 1'b0, 4'b0000);
      addVec(1'b0, 1'b0, 1'b0, 4'b0000);
    end
    addVec(1'b1, 1'b0, 1'b0, 4'b0000);

    // Read straight after one idle clk: addrWe, then srWe, then 8 pulses of misoBufe.
    addVec(1'b0, 1'b0, 1'b1, 4'b0000);
    for (int i = 1; i <= 8; i++) begin
      addVec(1'b0, 1'b1, 1'b1, {1'b0, (i == 8), 2'b00});
      addVec(1'b0, 1'b0, 1'b1, {(i == 8), 3'b000});
    end
    addVec(1'b0, 1'b0, 1'b1, 4'b0001);
    for (int i = 1; i <= 8; i++) begin
      addVec(1'b0, 1'b1, 1'b1, {3'b000, (i != 8)});
      addVec(1'b0, 1'b0, 1'b1, {3'b000, (i != 8)});
    end
    addVec(1'b1, 1'b0, 1'b0, 4'b0000);

    @(posedge clk);
    #1;
    checkOutput("reset_held", 4'b0000);
`ifdef SPI_FSM_STATUS_EN
    checkValue("reset_state", 8'(bus.fsmState), 8'd0);
    checkValue("reset_abort_count", bus.abortCount, 8'd0);
`endif
    @(posedge clk);
    #1;
    resetN = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("idle_cs_high", 4'b0000);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].cs, vecs[k].sclk, vecs[k].p0);
      checkOutput($sformatf("vec%0d", k), vecs[k].exp);
    end
`ifdef SPI_FSM_STATUS_EN
    checkValue("table_state_idle", 8'(bus.fsmState), 8'd0);
    checkValue("table_no_aborts", bus.abortCount, 8'd0);
`endif

    // Abort coincident with the 8th address pulse: no addrWe, straight to IDLE.
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("abort_pre", 4'b0000);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("abort_no_addrwe", 4'b0000);
`ifdef SPI_FSM_STATUS_EN
    checkValue("abort_state", 8'(bus.fsmState), 8'd0);
    checkValue("abort_count", bus.abortCount, 8'd1);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("abort_after", 4'b0000);

    // Fresh frame after the abort must need a full 8 pulses.
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("post_abort_p%0d", i), {1'b0, (i == 8), 2'b00});
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Reset mid-GET after 3 pulses, then a full 8-pulse frame is still required.
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("reset_mid_get", 4'b0000);
    @(posedge clk);
    #1;
    resetN = 1'b1;
`ifdef SPI_FSM_STATUS_EN
    checkValue("reset_release_state", 8'(bus.fsmState), 8'd0);
`endif
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, (i != 1), 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("reset_count_restart", 4'b0000);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("reset_count_8th", 4'b0100);

    // Reset while addrWe is high must drop it without waiting for a clock edge.
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("reset_in_got", 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("reset_in_got_held", 4'b0000);
    resetN = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("final_idle", 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
